// File: rtl/envelope_detector.sv
// Rectify-and-track amplitude envelope with hysteretic note gate; 2-cycle latency, 1 sample/cycle.
// No backpressure: every sample_valid is accepted, idle cycles hold all outputs.
module envelope_detector #(
  parameter int SAMPLE_W     = 16,
  parameter int HOLD_SAMPLES = 64,
  parameter int HOLD_W       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [3:0]          attack,
  input  logic        [3:0]          decay,
  input  logic        [SAMPLE_W-1:0] thresh_on,
  input  logic        [SAMPLE_W-1:0] thresh_off,
  output logic        [SAMPLE_W-1:0] envelope,
  output logic                       env_valid,
  output logic                       gate,
  output logic                       onset,
  output logic        [SAMPLE_W-1:0] peak,
  output logic        [1:0]          state
);

  localparam logic [SAMPLE_W-1:0] MAX_MAG = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] ONE     = {{(SAMPLE_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0]   HOLD_END = HOLD_W'(HOLD_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // ---------------- stage 1: rectify ----------------
  logic [SAMPLE_W-1:0] w_in_u;
  logic [SAMPLE_W-1:0] w_abs;
  logic [SAMPLE_W-1:0] w_rect;

  assign w_in_u = sample_in;
  assign w_abs  = sample_in[SAMPLE_W-1] ? (~w_in_u) + ONE : w_in_u;
  // Only the most-negative code wraps back to a set MSB.
  assign w_rect = w_abs[SAMPLE_W-1] ? MAX_MAG : w_abs;

  logic                r_s1_vld;
  logic [SAMPLE_W-1:0] r_rect;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_rect   <= '0;
    end else begin
      r_s1_vld <= sample_valid;
      if (sample_valid) r_rect <= w_rect;
    end
  end

  // ---------------- stage 2: envelope + gate ----------------
  logic                r_env_vld;
  logic                r_onset;
  logic [SAMPLE_W-1:0] r_env;
  logic [SAMPLE_W-1:0] r_peak;
  logic [HOLD_W-1:0]   r_hold;
  state_t              r_state;

  logic                w_rising;
  logic                w_falling;
  logic [SAMPLE_W-1:0] w_diff;
  logic [3:0]          w_shift;
  logic [SAMPLE_W-1:0] w_step_raw;
  logic [SAMPLE_W-1:0] w_step;
  logic [SAMPLE_W-1:0] w_env_sum;
  logic [SAMPLE_W-1:0] w_env_new;
  logic [SAMPLE_W-1:0] w_toff;
  logic [SAMPLE_W-1:0] w_peak_max;
  logic                w_above_on;
  logic                w_below_off;
  logic [HOLD_W-1:0]   w_hold_inc;

  assign w_rising   = r_rect > r_env;
  assign w_falling  = r_rect < r_env;
  // Both operands are bounded by MAX_MAG, so the difference fits in SAMPLE_W bits.
  assign w_diff     = w_rising ? r_rect - r_env : r_env - r_rect;
  assign w_shift    = w_rising ? attack : decay;
  assign w_step_raw = w_diff >> w_shift;
  // Minimum step of 1 so the envelope lands exactly on a steady input.
  assign w_step     = (w_step_raw == '0 && w_diff != '0) ? ONE : w_step_raw;

  always_comb begin
    w_env_sum = r_env;
    if (w_rising)       w_env_sum = r_env + w_step;
    else if (w_falling) w_env_sum = r_env - w_step;
  end

  assign w_env_new   = (w_env_sum > MAX_MAG) ? MAX_MAG : w_env_sum;
  assign w_toff      = (thresh_off < thresh_on) ? thresh_off : thresh_on;
  assign w_above_on  = w_env_new >= thresh_on;
  assign w_below_off = w_env_new < w_toff;
  assign w_peak_max  = (w_env_new > r_peak) ? w_env_new : r_peak;
  assign w_hold_inc  = r_hold + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_env_vld <= 1'b0;
      r_onset   <= 1'b0;
      r_env     <= '0;
      r_peak    <= '0;
      r_hold    <= '0;
      r_state   <= S_IDLE;
    end else begin
      r_env_vld <= r_s1_vld;
      r_onset   <= 1'b0;
      if (r_s1_vld) begin
        r_env <= w_env_new;
        case (r_state)
          S_IDLE: begin
            if (w_above_on) begin
              r_state <= S_ATTACK;
              r_onset <= 1'b1;
              r_peak  <= w_env_new;
            end
          end
          S_ATTACK: begin
            r_peak <= w_peak_max;
            if (w_below_off) begin
              r_state <= S_RELEASE;
              r_hold  <= '0;
            end else if (!w_rising) begin
              r_state <= S_SUSTAIN;
            end
          end
          S_SUSTAIN: begin
            // A renewed rise while sustaining does not retrigger the note.
            r_peak <= w_peak_max;
            if (w_below_off) begin
              r_state <= S_RELEASE;
              r_hold  <= '0;
            end
          end
          S_RELEASE: begin
            if (w_above_on) begin
              r_state <= S_ATTACK;
              r_onset <= 1'b1;
              r_peak  <= w_env_new;
            end else begin
              r_peak <= w_peak_max;
              r_hold <= w_hold_inc;
              if (w_hold_inc == HOLD_END) r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign envelope  = r_env;
  assign env_valid = r_env_vld;
  assign onset     = r_onset;
  assign peak      = r_peak;
  assign state     = r_state;
  assign gate      = (r_state != S_IDLE);

endmodule

// File: tb/tb_envelope_detector.sv
// Bench for envelope_detector: directed scenarios with literal expectations plus
// randomized traffic, all compared cycle by cycle against an arithmetic model.
module tb_envelope_detector;

  localparam int W    = 16;
  localparam int HOLD = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                sample_valid = 1'b0;
  logic signed [W-1:0] sample_in = '0;
  logic [3:0]          attack = 4'd0;
  logic [3:0]          decay  = 4'd0;
  logic [W-1:0]        thresh_on  = 16'hFFFF;
  logic [W-1:0]        thresh_off = 16'd0;
  logic [W-1:0]        envelope;
  logic                env_valid;
  logic                gate;
  logic                onset;
  logic [W-1:0]        peak;
  logic [1:0]          state;

  envelope_detector #(.SAMPLE_W(W), .HOLD_SAMPLES(HOLD), .HOLD_W(8)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .attack(attack), .decay(decay), .thresh_on(thresh_on), .thresh_off(thresh_off),
    .envelope(envelope), .env_valid(env_valid), .gate(gate), .onset(onset),
    .peak(peak), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: expected outputs after the coming clock edge.
  int m_env = 0, m_peak = 0, m_state = 0, m_cnt = 0;
  bit m_vld = 0, m_onset = 0;
  bit pend_vld = 0;
  int pend_rect = 0;

  function automatic int abs_sat(input int s);
    int a;
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  task automatic model_update(input int r);
    bit rising, on;
    int d, st, e, ton, toff, nxt;
    rising = (r > m_env);
    if (r > m_env) begin
      d = r - m_env; st = d >> attack; if (st == 0) st = 1; m_env = m_env + st;
    end else if (r < m_env) begin
      d = m_env - r; st = d >> decay; if (st == 0) st = 1; m_env = m_env - st;
    end
    e    = m_env;
    ton  = int'(thresh_on);
    toff = (int'(thresh_off) < ton) ? int'(thresh_off) : ton;
    nxt  = m_state;
    on   = 0;
    if (m_state == 0) begin
      if (e >= ton) begin nxt = 1; on = 1; end
    end else if (m_state == 3) begin
      if (e >= ton) begin nxt = 1; on = 1; end
      else begin m_cnt = m_cnt + 1; if (m_cnt == HOLD) nxt = 0; end
    end else if (e < toff) begin
      nxt = 3; m_cnt = 0;
    end else if (m_state == 1 && !rising) begin
      nxt = 2;
    end
    if (on) m_peak = e;
    else if (m_state != 0 && e > m_peak) m_peak = e;
    m_state = nxt;
    m_onset = on;
  endtask

  // Drive one cycle: inputs change on the falling edge, results are sampled 1 time unit after the rising edge.
  task automatic step(input bit r, input bit v, input int s);
    @(negedge clock);
    reset        = r;
    sample_valid = v;
    sample_in    = s[W-1:0];
    if (r) begin
      m_env = 0; m_peak = 0; m_state = 0; m_cnt = 0;
      m_vld = 0; m_onset = 0; pend_vld = 0;
    end else begin
      m_vld   = pend_vld;
      m_onset = 0;
      if (pend_vld) model_update(pend_rect);
      pend_vld  = v;
      pend_rect = abs_sat(s);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(posedge clock) begin
    #1;
    checks++;
    if (envelope !== 16'(m_env) || env_valid !== m_vld || onset !== m_onset ||
        peak !== 16'(m_peak) || state !== 2'(m_state) || gate !== (m_state != 0)) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t dut env=%0d vld=%b onset=%b peak=%0d state=%0d gate=%b model env=%0d vld=%b onset=%b peak=%0d state=%0d",
               $time, envelope, env_valid, onset, peak, state, gate,
               m_env, m_vld, m_onset, m_peak, m_state);
    end
  end

  int att_exp [4] = '{256, 448, 592, 700};

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_env", int'(envelope), 0);
    chk("reset_state", int'(state), 0);

    // Reset mid-stream while samples are arriving.
    step(0, 1, 500);
    step(0, 1, 600);
    step(1, 1, 700);
    step(1, 1, 800);
    chk("midrst_env", int'(envelope), 0);
    chk("midrst_peak", int'(peak), 0);
    chk("midrst_state", int'(state), 0);
    chk("midrst_gate", int'(gate), 0);
    step(0, 0, 0);
    chk("midrst_no_vld", int'(env_valid), 0);

    // Instant tracking.
    attack = 0; decay = 0;
    step(0, 1, 1000);
    step(0, 0, 0);
    chk("inst_vld", int'(env_valid), 1);
    chk("inst_1000", int'(envelope), 1000);
    step(0, 1, -32768);
    step(0, 0, 0);
    chk("inst_mostneg", int'(envelope), 32767);
    step(0, 1, -5);
    step(0, 0, 0);
    chk("inst_neg5", int'(envelope), 5);

    // Attack rate from zero.
    step(0, 1, 0);
    step(0, 0, 0);
    chk("att_zero", int'(envelope), 0);
    attack = 2;
    step(0, 1, 1024);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1024);
      chk($sformatf("att_step%0d", i), int'(envelope), att_exp[i]);
    end
    for (int i = 0; i < 60; i++) step(0, 1, 1024);
    chk("att_converge", int'(envelope), 1024);

    // Decay floor.
    decay = 0;
    step(0, 1, 20);
    step(0, 1, 0);
    chk("dec_start", int'(envelope), 20);
    decay = 4;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 0);
      if (i == 1)  chk("dec_first", int'(envelope), 19);
      if (i == 19) chk("dec_19", int'(envelope), 1);
      if (i == 20) chk("dec_20", int'(envelope), 0);
    end

    // Gate cycle with hold.
    attack = 0; decay = 0; thresh_on = 8000; thresh_off = 4000;
    step(0, 1, 10000);
    step(0, 1, 10000);
    chk("gate_onset", int'(onset), 1);
    chk("gate_attack", int'(state), 1);
    chk("gate_peak", int'(peak), 10000);
    step(0, 1, 0);
    chk("gate_sustain", int'(state), 2);
    step(0, 1, 0);
    chk("gate_release", int'(state), 3);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("gate_hold3", int'(state), 3);
    step(0, 1, 10000);
    chk("gate_idle", int'(state), 0);
    chk("gate_closed", int'(gate), 0);

    // Retrigger from RELEASE and off-threshold clamping.
    step(0, 1, 0);
    chk("re_open", int'(state), 1);
    step(0, 1, 9000);
    chk("re_release", int'(state), 3);
    step(0, 1, 8500);
    chk("re_onset", int'(onset), 1);
    chk("re_attack", int'(state), 1);
    chk("re_peak", int'(peak), 9000);
    thresh_off = 9500;
    step(0, 1, 7999);
    chk("hyst_sustain", int'(state), 2);
    step(0, 1, 0);
    chk("hyst_release", int'(state), 3);

    // Randomized traffic.
    thresh_on = 12000; thresh_off = 6000;
    for (int i = 0; i < 3000; i++) begin
      int s;
      if ($urandom_range(0, 15) == 0) attack = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) decay  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) thresh_on  = 16'($urandom_range(0, 20000));
      if ($urandom_range(0, 63) == 0) thresh_off = 16'($urandom_range(0, 20000));
      case ($urandom_range(0, 7))
        0, 1:    s = 0;
        2:       s = -32768;
        3:       s = $urandom_range(0, 200) - 100;
        default: s = int'($urandom_range(0, 65535)) - 32768;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
